bpu_btb: RTL and testbench
==========================

# bpu_btb

Parametrised branch target buffer with per-entry 2-bit saturating direction counters, succeeding the fixed 256-entry single-cycle predictor. It sits beside the IF stage: IF presents the fetch PC each cycle and receives a registered taken/target prediction one cycle later; the resolving stage (ID) returns the actual outcome through a separate update port. The block adds tag-checked hits, target storage with allocate-on-taken, same-cycle update/lookup forwarding, and an optional gshare index hash.

## Interface
- `XLEN`, 32, PC and target width
- `INDEX_WIDTH`, 6, log2 of entry count (64 entries); tag = `pc[XLEN-1:INDEX_WIDTH+2]`
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_lookup_valid`  in  1  fetch PC valid this cycle
- `i_lookup_pc`  in  XLEN  fetch PC, word aligned
- `o_pred_valid`  out  1  registered; prediction for last cycle's lookup
- `o_pred_hit`  out  1  tag matched a valid entry
- `o_pred_taken`  out  1  predicted taken
- `o_pred_target`  out  XLEN  next PC: stored target if taken, else lookup PC + 4
- `o_pred_ghr`  out  INDEX_WIDTH  history snapshot used for the lookup; 0 without gshare
- `i_upd_valid`  in  1  resolved branch this cycle
- `i_upd_pc`  in  XLEN  PC of resolved branch
- `i_upd_target`  in  XLEN  actual branch target
- `i_upd_taken`  in  1  actual direction
- `i_upd_ghr`  in  INDEX_WIDTH  `o_pred_ghr` carried down the pipe with the branch; ignored without gshare

## Operation
- Entry: valid, tag, target, 2-bit counter (SNT=00, WNT=01, WT=10, ST=11).
- Index = `pc[INDEX_WIDTH+1:2]` (XOR history under gshare); PC bits [1:0] are ignored.
- Lookup: hit = valid & tag equal; taken = hit & counter[1]; target = taken ? entry target : pc+4.
- Update on `i_upd_valid`, at the index computed from `i_upd_pc` and `i_upd_ghr`:
  - hit: counter saturating +1 if taken, −1 if not; target overwritten when taken.
  - miss and taken: allocate; valid=1, tag and target written, counter=WT; any aliasing entry is evicted.
  - miss and not taken: no change.
- Lookup and update to the same index in the same cycle: the lookup observes the post-update entry (write-first forwarding).
- `i_lookup_valid`=0: next cycle `o_pred_valid`, `o_pred_hit` and `o_pred_taken` are 0; `o_pred_target` and `o_pred_ghr` are 0.

## Timing
- Lookup latency 1 cycle: inputs sampled at edge k, outputs valid after edge k until edge k+1.
- Update is written at the edge it is sampled and is visible to a lookup sampled at that same edge (via forwarding) and to all later lookups.
- No backpressure: one lookup and one update accepted every cycle.
- Reset (asynchronous, immediate on `rst_n` low, including mid-operation): all outputs 0, all valid bits 0, all counters WNT, GHR 0. Tag and target arrays are not reset. The first lookup is accepted at the first edge after `rst_n` deasserts.

## Configuration
- `BPU_GSHARE_EN` defined: an INDEX_WIDTH-bit global history register shifts left by one, inserting `i_upd_taken` at bit 0, on every `i_upd_valid`. The lookup index is `pc[INDEX_WIDTH+1:2] ^ ghr`, using the pre-shift value. `o_pred_ghr` carries that value, and the update index uses `i_upd_ghr`.
- Not defined: no history register; plain PC index; `o_pred_ghr` drives 0; `i_upd_ghr` is unused.

## Test plan
- Reset then lookup 0x104 -> `o_pred_valid`=1, hit=0, taken=0, target=0x108.
- Update 0x104 taken target 0x200, then lookup 0x104 -> hit=1, taken=1, target=0x200.
- From WT: 3 not-taken updates -> SNT, lookup gives hit=1, taken=0, target=0x108. A 4th not-taken update leaves SNT. One taken update -> taken=0; a second taken update -> taken=1.
- After the 0x104 allocation, update 0x204 taken target 0x300 (same index 1, tag 2) -> lookup 0x104 gives hit=0, target=0x108; lookup 0x204 gives target=0x300.
- Same-cycle update of 0x104 taken target 0x200 (fresh table) and lookup 0x104 -> next cycle hit=1, taken=1, target=0x200.
- Drop `rst_n` between edges mid-traffic -> outputs 0 immediately; after release, lookup 0x104 gives hit=0.

Source files
------------

// File: rtl/bpu_btb.sv
`default_nettype none
// ============================================================================
// Module      : bpu_btb
// Description : Tag-checked branch target buffer with 2-bit direction counters,
//               registered one-cycle prediction and write-first update
//               forwarding. Define BPU_GSHARE_EN to XOR a global history
//               register into the table index.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_btb #(
    parameter int XLEN        = 32,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_lookup_valid,
    input  logic [XLEN-1:0]        i_lookup_pc,
    output logic                   o_pred_valid,
    output logic                   o_pred_hit,
    output logic                   o_pred_taken,
    output logic [XLEN-1:0]        o_pred_target,
    output logic [INDEX_WIDTH-1:0] o_pred_ghr,
    input  logic                   i_upd_valid,
    input  logic [XLEN-1:0]        i_upd_pc,
    input  logic [XLEN-1:0]        i_upd_target,
    input  logic                   i_upd_taken,
    input  logic [INDEX_WIDTH-1:0] i_upd_ghr
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = XLEN - INDEX_WIDTH - 2;

    localparam logic [1:0] c_cnt_snt = 2'b00;
    localparam logic [1:0] c_cnt_wnt = 2'b01;
    localparam logic [1:0] c_cnt_wt  = 2'b10;
    localparam logic [1:0] c_cnt_st  = 2'b11;

    logic [ENTRIES-1:0]     valid_q;
    logic [1:0]             cnt_q [ENTRIES];
    logic [TAG_W-1:0]       tag_q [ENTRIES];
    logic [XLEN-1:0]        tgt_q [ENTRIES];

    logic                   pred_valid_q, pred_hit_q, pred_taken_q;
    logic [XLEN-1:0]        pred_target_q;
    logic [INDEX_WIDTH-1:0] pred_ghr_q;

    logic [INDEX_WIDTH-1:0] w_lk_idx, w_upd_idx, w_lk_ghr;
    logic [TAG_W-1:0]       w_lk_tag, w_upd_tag;
    logic                   w_unused_bits;

    assign w_lk_tag  = i_lookup_pc[XLEN-1:INDEX_WIDTH+2];
    assign w_upd_tag = i_upd_pc[XLEN-1:INDEX_WIDTH+2];

`ifdef BPU_GSHARE_EN
    logic [INDEX_WIDTH-1:0] ghr_q, ghr_d;

    assign ghr_d     = i_upd_valid ? {ghr_q[INDEX_WIDTH-2:0], i_upd_taken} : ghr_q;
    assign w_lk_ghr  = ghr_q;
    assign w_lk_idx  = i_lookup_pc[INDEX_WIDTH+1:2] ^ ghr_q;
    assign w_upd_idx = i_upd_pc[INDEX_WIDTH+1:2] ^ i_upd_ghr;
    assign w_unused_bits = ^i_upd_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end
`else
    assign w_lk_ghr  = '0;
    assign w_lk_idx  = i_lookup_pc[INDEX_WIDTH+1:2];
    assign w_upd_idx = i_upd_pc[INDEX_WIDTH+1:2];
    assign w_unused_bits = ^{i_upd_pc[1:0], i_upd_ghr};
`endif

    // Post-update image of the entry addressed by the update port.
    logic                   w_upd_hit, w_upd_we, w_tgt_we;
    logic                   w_new_valid;
    logic [1:0]             w_new_cnt;
    logic [TAG_W-1:0]       w_new_tag;
    logic [XLEN-1:0]        w_new_tgt;

    assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);
    assign w_tgt_we  = i_upd_valid && i_upd_taken;

    always_comb begin
        w_upd_we    = 1'b0;
        w_new_valid = valid_q[w_upd_idx];
        w_new_cnt   = cnt_q[w_upd_idx];
        w_new_tag   = tag_q[w_upd_idx];
        w_new_tgt   = tgt_q[w_upd_idx];
        if (i_upd_valid) begin
            if (w_upd_hit) begin
                w_upd_we = 1'b1;
                if (i_upd_taken) begin
                    w_new_tgt = i_upd_target;
                    if (w_new_cnt != c_cnt_st) w_new_cnt = w_new_cnt + 2'd1;
                end else if (w_new_cnt != c_cnt_snt) begin
                    w_new_cnt = w_new_cnt - 2'd1;
                end
            end else if (i_upd_taken) begin
                w_upd_we    = 1'b1;
                w_new_valid = 1'b1;
                w_new_cnt   = c_cnt_wt;
                w_new_tag   = w_upd_tag;
                w_new_tgt   = i_upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= c_cnt_wnt;
        end else if (w_upd_we) begin
            valid_q[w_upd_idx] <= w_new_valid;
            cnt_q[w_upd_idx]   <= w_new_cnt;
        end
    end

    // Tag and target storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_tgt_we) begin
            tag_q[w_upd_idx] <= w_new_tag;
            tgt_q[w_upd_idx] <= w_new_tgt;
        end
    end

    logic                   w_fwd, w_lk_valid, w_lk_hit, w_lk_taken;
    logic [1:0]             w_lk_cnt;
    logic [TAG_W-1:0]       w_lk_etag;
    logic [XLEN-1:0]        w_lk_etgt, w_lk_target;

    assign w_fwd       = i_upd_valid && (w_lk_idx == w_upd_idx);
    assign w_lk_valid  = w_fwd ? w_new_valid : valid_q[w_lk_idx];
    assign w_lk_cnt    = w_fwd ? w_new_cnt   : cnt_q[w_lk_idx];
    assign w_lk_etag   = w_fwd ? w_new_tag   : tag_q[w_lk_idx];
    assign w_lk_etgt   = w_fwd ? w_new_tgt   : tgt_q[w_lk_idx];
    assign w_lk_hit    = w_lk_valid && (w_lk_etag == w_lk_tag);
    assign w_lk_taken  = w_lk_hit && w_lk_cnt[1];
    assign w_lk_target = w_lk_taken ? w_lk_etgt : i_lookup_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_ghr_q    <= '0;
        end else if (i_lookup_valid) begin
            pred_valid_q  <= 1'b1;
            pred_hit_q    <= w_lk_hit;
            pred_taken_q  <= w_lk_taken;
            pred_target_q <= w_lk_target;
            pred_ghr_q    <= w_lk_ghr;
        end else begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_ghr_q    <= '0;
        end
    end

    assign o_pred_valid  = pred_valid_q;
    assign o_pred_hit    = pred_hit_q;
    assign o_pred_taken  = pred_taken_q;
    assign o_pred_target = pred_target_q;
    assign o_pred_ghr    = pred_ghr_q;

endmodule
`default_nettype wire

// File: tb/tb_bpu_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpu_btb
// Description : Directed scoreboard bench for bpu_btb (default, non-gshare).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpu_btb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic [5:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken;
    logic [5:0]  upd_ghr;

    bpu_btb #(.XLEN(32), .INDEX_WIDTH(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_lookup_valid(lookup_valid),
        .i_lookup_pc   (lookup_pc),
        .o_pred_valid  (pred_valid),
        .o_pred_hit    (pred_hit),
        .o_pred_taken  (pred_taken),
        .o_pred_target (pred_target),
        .o_pred_ghr    (pred_ghr),
        .i_upd_valid   (upd_valid),
        .i_upd_pc      (upd_pc),
        .i_upd_target  (upd_target),
        .i_upd_taken   (upd_taken),
        .i_upd_ghr     (upd_ghr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        h;
        logic        t;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string name, input exp_t e);
        chk({name, ".valid"},  32'(pred_valid),  32'(e.v));
        chk({name, ".hit"},    32'(pred_hit),    32'(e.h));
        chk({name, ".taken"},  32'(pred_taken),  32'(e.t));
        chk({name, ".target"}, pred_target,      e.tgt);
        chk({name, ".ghr"},    32'(pred_ghr),    32'd0);
    endtask

    // Called just after a falling edge; drives one cycle, checks after the rising edge.
    task automatic step(input string name,
                        input bit lv, input logic [31:0] lpc,
                        input bit uv, input logic [31:0] upc, input logic [31:0] utgt, input bit ut,
                        input bit eh, input bit et, input logic [31:0] etgt);
        exp_t e;
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_target   = utgt;
        upd_taken    = ut;
        upd_ghr      = 6'h2A;
        q.push_back(lv ? exp_t'{1'b1, eh, et, etgt} : exp_t'{1'b0, 1'b0, 1'b0, 32'h0});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL %s scoreboard empty observed=1 expected=0", name);
        end else begin
            e = q.pop_front();
            chk_all(name, e);
        end
        @(negedge clk);
    endtask

    task automatic upd(input string name, input logic [31:0] pc, input logic [31:0] tgt, input bit t);
        step(name, 1'b0, 32'h0, 1'b1, pc, tgt, t, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic look(input string name, input logic [31:0] pc, input bit eh, input bit et,
                        input logic [31:0] etgt);
        step(name, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, eh, et, etgt);
    endtask

    initial begin
        rst_n        = 1'b0;
        lookup_valid = 1'b0;
        lookup_pc    = '0;
        upd_valid    = 1'b0;
        upd_pc       = '0;
        upd_target   = '0;
        upd_taken    = 1'b0;
        upd_ghr      = '0;
        repeat (2) @(negedge clk);
        chk_all("reset", exp_t'{1'b0, 1'b0, 1'b0, 32'h0});
        rst_n = 1'b1;

        look("cold_lookup", 32'h104, 1'b0, 1'b0, 32'h108);
        upd ("alloc_104",   32'h104, 32'h200, 1'b1);
        look("hit_104",     32'h104, 1'b1, 1'b1, 32'h200);
        upd ("nt1", 32'h104, 32'h0, 1'b0);
        upd ("nt2", 32'h104, 32'h0, 1'b0);
        look("after_nt2",   32'h104, 1'b1, 1'b0, 32'h108);
        upd ("nt3", 32'h104, 32'h0, 1'b0);
        look("after_nt3",   32'h104, 1'b1, 1'b0, 32'h108);
        upd ("nt4", 32'h104, 32'h0, 1'b0);
        upd ("t1",  32'h104, 32'h200, 1'b1);
        look("after_t1",    32'h104, 1'b1, 1'b0, 32'h108);
        upd ("t2",  32'h104, 32'h200, 1'b1);
        look("after_t2",    32'h104, 1'b1, 1'b1, 32'h200);

        upd ("alloc_204",   32'h204, 32'h300, 1'b1);
        look("evicted_104", 32'h104, 1'b0, 1'b0, 32'h108);
        look("hit_204",     32'h204, 1'b1, 1'b1, 32'h300);
        upd ("miss_nt_404", 32'h404, 32'h500, 1'b0);
        look("kept_204",    32'h204, 1'b1, 1'b1, 32'h300);
        look("wrap_pc",     32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        look("other_idx",   32'h108, 1'b0, 1'b0, 32'h10C);

        // Fresh table for forwarding.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        step("fwd_alloc", 1'b1, 32'h104, 1'b1, 32'h104, 32'h200, 1'b1, 1'b1, 1'b1, 32'h200);
        step("fwd_dec",   1'b1, 32'h104, 1'b1, 32'h104, 32'h0,   1'b0, 1'b1, 1'b0, 32'h108);
        step("fwd_other", 1'b1, 32'h108, 1'b1, 32'h104, 32'h0,   1'b0, 1'b0, 1'b0, 32'h10C);
        step("fwd_inc",   1'b1, 32'h104, 1'b1, 32'h104, 32'h240, 1'b1, 1'b1, 1'b0, 32'h108);
        step("fwd_inc2",  1'b1, 32'h104, 1'b1, 32'h104, 32'h280, 1'b1, 1'b1, 1'b1, 32'h280);

        // Asynchronous reset between edges while a hit prediction is on the outputs.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", exp_t'{1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        look("post_reset",  32'h104, 1'b0, 1'b0, 32'h108);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
